// File: rtl/game_pkg.sv
// Shared definitions for the player-state UART frame encoder.
//   TAG_HDR / TAG_CSUM : tag nibbles of the header and checksum bytes
//   enc_state_t        : frame encoder FSM states
//   frame_bytes()      : frame length in bytes for a given coordinate width
package game_pkg;

  localparam logic [3:0] TAG_HDR  = 4'h0;
  localparam logic [3:0] TAG_CSUM = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } enc_state_t;

  // header + x nibbles + y nibbles + collision + checksum
  function automatic int frame_bytes(input int coord_w);
    return 2 * (coord_w / 4) + 3;
  endfunction

endpackage

// File: rtl/uart_period_tick.sv
// Periodic request timer for automatic frame generation.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   en   : run enable; the counter is held at zero while low
//   tick : registered one-cycle pulse every PERIOD cycles while en=1
// PERIOD=0 disables the timer permanently (tick stays low).
module uart_period_tick #(
  parameter int PERIOD = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int              CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0]   TC     = CW'((PERIOD > 0) ? PERIOD - 1 : 0);
  localparam bit              ACTIVE = (PERIOD > 0);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          run;

  assign run = en && ACTIVE;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (!run) begin
      cnt_d = '0;
    end else if (cnt_q == TC) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_frame_encoder.sv
// Player-state UART frame encoder.
// Snapshots one player's coordinates and collision flag, then writes a
// nibble-tagged frame {payload, tag} into the UART TX FIFO, closed by an
// XOR checksum byte (tag 0xF).
//   clk, rst      : system clock, asynchronous active-high reset
//   frame_req     : single-cycle frame request
//   auto_en       : enables the periodic request timer (AUTO_PERIOD>0)
//   sel_player    : player to report; out-of-range gives zero payloads
//   x_in, y_in    : packed coordinates, player p at [p*COORD_W +: COORD_W]
//   collision_in  : per-player collision flags
//   tx_full       : FIFO full, stalls byte emission
//   wr_uart       : FIFO write strobe, w_data valid while high
//   busy          : high from LOAD through DONE
//   frame_done    : one-cycle pulse after the last byte of a frame
//
// state | meaning
// IDLE  | waiting for a pending or fresh request
// LOAD  | snapshot selected player, clear byte index and checksum
// SEND  | emit bytes under tx_full back-pressure, one every 2 cycles max
// DONE  | frame complete, raise frame_done
module uart_frame_encoder
  import game_pkg::*;
#(
  parameter int N_PLAYERS   = 2,
  parameter int COORD_W     = 8,
  parameter int AUTO_PERIOD = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_req,
  input  logic                           auto_en,
  input  logic [3:0]                     sel_player,
  input  logic [N_PLAYERS*COORD_W-1:0]   x_in,
  input  logic [N_PLAYERS*COORD_W-1:0]   y_in,
  input  logic [N_PLAYERS-1:0]           collision_in,
  input  logic                           tx_full,
  output logic                           wr_uart,
  output logic [7:0]                     w_data,
  output logic                           busy,
  output logic                           frame_done
);

  localparam int         NIB      = COORD_W / 4;
  localparam int         BYTES    = frame_bytes(COORD_W);
  localparam logic [4:0] IDX_COLL = 5'(2 * NIB + 1);
  localparam logic [4:0] IDX_CSUM = 5'(BYTES - 1);

  enc_state_t           state_q, state_d;
  logic                 pending_q, pending_d;
  logic [3:0]           snap_sel_q, snap_sel_d;
  logic [COORD_W-1:0]   snap_x_q, snap_x_d;
  logic [COORD_W-1:0]   snap_y_q, snap_y_d;
  logic                 snap_coll_q, snap_coll_d;
  logic [4:0]           byte_idx_q, byte_idx_d;
  logic [3:0]           csum_q, csum_d;
  logic [7:0]           byte_q, byte_d;
  logic                 byte_vld_q, byte_vld_d;
  logic                 wr_uart_q, wr_uart_d;
  logic [7:0]           w_data_q, w_data_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;

  logic                 auto_tick;
  logic [COORD_W-1:0]   sel_x, sel_y;
  logic                 sel_coll;
  logic [3:0]           mux_payload, mux_tag;

  uart_period_tick #(
    .PERIOD (AUTO_PERIOD)
  ) u_auto_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (auto_en),
    .tick (auto_tick)
  );

  // Player select; indices beyond N_PLAYERS match nothing and leave zeros.
  always_comb begin
    sel_x    = '0;
    sel_y    = '0;
    sel_coll = 1'b0;
    for (int p = 0; p < N_PLAYERS; p++) begin
      if (sel_player == 4'(p)) begin
        sel_x    = x_in[p*COORD_W +: COORD_W];
        sel_y    = y_in[p*COORD_W +: COORD_W];
        sel_coll = collision_in[p];
      end
    end
  end

  // Byte for the current index, taken from the snapshot only.
  always_comb begin
    mux_payload = 4'h0;
    mux_tag     = byte_idx_q[3:0];
    if (byte_idx_q == 5'd0) begin
      mux_payload = snap_sel_q;
      mux_tag     = TAG_HDR;
    end else if (byte_idx_q == IDX_COLL) begin
      mux_payload = {3'b000, snap_coll_q};
    end else if (byte_idx_q == IDX_CSUM) begin
      mux_payload = csum_q;
      mux_tag     = TAG_CSUM;
    end else begin
      for (int i = 0; i < NIB; i++) begin
        if (byte_idx_q == 5'(i + 1))       mux_payload = snap_x_q[4*i +: 4];
        if (byte_idx_q == 5'(NIB + i + 1)) mux_payload = snap_y_q[4*i +: 4];
      end
    end
  end

  // The byte mux is staged through byte_q so the nibble select stays off the
  // w_data path. byte_vld_q marks byte_q as current for byte_idx_q; it drops
  // on every emit, which also enforces the gap cycle between writes.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | frame_req | auto_tick;
    snap_sel_d   = snap_sel_q;
    snap_x_d     = snap_x_q;
    snap_y_d     = snap_y_q;
    snap_coll_d  = snap_coll_q;
    byte_idx_d   = byte_idx_q;
    csum_d       = csum_q;
    byte_d       = byte_q;
    byte_vld_d   = byte_vld_q;
    wr_uart_d    = 1'b0;
    w_data_d     = w_data_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pending_q || frame_req) begin
          state_d   = LOAD;
          pending_d = 1'b0;
        end
      end
      LOAD: begin
        snap_sel_d  = sel_player;
        snap_x_d    = sel_x;
        snap_y_d    = sel_y;
        snap_coll_d = sel_coll;
        byte_idx_d  = 5'd0;
        csum_d      = 4'h0;
        byte_vld_d  = 1'b0;
        state_d     = SEND;
      end
      SEND: begin
        if (byte_vld_q && !tx_full && !wr_uart_q) begin
          wr_uart_d  = 1'b1;
          w_data_d   = byte_q;
          csum_d     = csum_q ^ byte_q[7:4];
          byte_vld_d = 1'b0;
          if (byte_idx_q == IDX_CSUM) begin
            state_d = DONE;
          end else begin
            byte_idx_d = byte_idx_q + 5'd1;
          end
        end else begin
          byte_d     = {mux_payload, mux_tag};
          byte_vld_d = 1'b1;
        end
      end
      DONE: begin
        frame_done_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      snap_sel_q   <= 4'h0;
      snap_x_q     <= '0;
      snap_y_q     <= '0;
      snap_coll_q  <= 1'b0;
      byte_idx_q   <= 5'd0;
      csum_q       <= 4'h0;
      byte_q       <= 8'h00;
      byte_vld_q   <= 1'b0;
      wr_uart_q    <= 1'b0;
      w_data_q     <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      snap_sel_q   <= snap_sel_d;
      snap_x_q     <= snap_x_d;
      snap_y_q     <= snap_y_d;
      snap_coll_q  <= snap_coll_d;
      byte_idx_q   <= byte_idx_d;
      csum_q       <= csum_d;
      byte_q       <= byte_d;
      byte_vld_q   <= byte_vld_d;
      wr_uart_q    <= wr_uart_d;
      w_data_q     <= w_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wr_uart    = wr_uart_q;
  assign w_data     = w_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/uart_frame_encoder.md
Name: uart_frame_encoder

Overview:
- Parametrised successor to the fixed 6-byte player-state UART packer.
- Serialises one selected player's position and collision state into a nibble-tagged byte frame with a trailing checksum.
- Writes the bytes into the UART TX FIFO under tx_full back-pressure.
- Frames are sent on request or periodically. Inputs are snapshotted at frame start so a frame is always self-consistent.

Parameters:
- N_PLAYERS, 2, number of player channels (1..16).
- COORD_W, 8, coordinate width in bits; multiple of 4, 4..24.
- AUTO_PERIOD, 0, clock cycles between automatic frame requests; 0 disables auto mode.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- frame_req  in  1  single-cycle frame request.
- auto_en  in  1  enables the periodic request timer.
- sel_player  in  4  index of the player to report.
- x_in  in  N_PLAYERS*COORD_W  packed x coordinates; player p occupies [p*COORD_W +: COORD_W].
- y_in  in  N_PLAYERS*COORD_W  packed y coordinates, same packing as x_in.
- collision_in  in  N_PLAYERS  per-player collision flags.
- tx_full  in  1  UART TX FIFO full.
- wr_uart  out  1  FIFO write strobe, single-cycle pulse.
- w_data  out  8  byte to write; valid while wr_uart=1.
- busy  out  1  high from LOAD through DONE inclusive.
- frame_done  out  1  one-cycle pulse after the last byte of a frame.

Behaviour:
- All outputs and state are registered. Async reset clears: wr_uart=0, w_data=0, busy=0, frame_done=0, state=IDLE, pending=0, timer=0, snapshot=0.
- Reset asserted mid-frame aborts the frame immediately. No further bytes are written; the frame is not resumed.
- Byte format: {payload[3:0], tag[3:0]}. NIB = COORD_W/4. Frame length BYTES = 2*NIB+3 (7 by default). Bytes in send order:
  - tag 0: payload = sel_player.
  - tags 1..NIB: x nibbles, least-significant nibble first.
  - tags NIB+1..2*NIB: y nibbles, least-significant nibble first.
  - tag 2*NIB+1: payload = {3'b000, collision}.
  - tag 0xF: payload = XOR of the payloads of all preceding bytes in the frame.
- sel_player >= N_PLAYERS: coordinate and collision payloads are 0; the header still carries sel_player.
- Request sources and pending flag:
  - frame_req, or an auto tick, sets pending.
  - Requests arriving while busy collapse into one pending flag and are served after DONE.
  - pending clears on entry to LOAD.
- Auto timer: free-running counter active only while auto_en=1 and AUTO_PERIOD>0. It asserts a tick and reloads when it reaches AUTO_PERIOD-1. It clears while auto_en=0.
- State machine:
  - IDLE: if pending, or frame_req this cycle, go to LOAD.
  - LOAD (1 cycle): snapshot sel_player, the selected x, y and collision; byte_idx=0, csum=0; go to SEND. Input changes after LOAD do not affect the current frame.
  - SEND: a byte is emitted only if tx_full=0 and wr_uart=0 in the current cycle. Emitting means: register wr_uart=1 and w_data=byte(byte_idx), csum ^= payload, byte_idx++. The result is at most one write every 2 cycles, which tolerates one cycle of FIFO flag latency. Once the checksum byte is emitted, go to DONE.
  - tx_full=1 in SEND: hold byte_idx and keep wr_uart=0; stall indefinitely with no byte lost.
  - DONE (1 cycle): frame_done=1; go to IDLE.
- Latency with tx_full=0:
  - frame_req sampled at edge E gives LOAD after E and the first wr_uart high after E+3.
  - Remaining bytes follow every 2 cycles.
  - frame_done is high in the cycle after the last wr_uart cycle.
- frame_req in the same cycle as the DONE→IDLE transition is captured in pending; it is not lost.

Decomposition:
- game_pkg gains:
  - TAG_HDR=4'h0 and TAG_CSUM=4'hF.
  - An enc_state_t enum {IDLE, LOAD, SEND, DONE}.
  - A function computing the frame length from COORD_W.
- Sub-module uart_period_tick (parameter PERIOD; ports clk, rst, en, tick) implements the auto-request timer.

Test Plan:
- Default params, tx_full=0, sel=1, x1=0xA5, y1=0x3C, coll1=1, pulse frame_req → w_data sequence 0x10,0x51,0xA2,0xC3,0x34,0x15,0x0F on alternate cycles; frame_done 1 cycle after the last write.
- Same frame with tx_full=1 held for 10 cycles after the 3rd byte → no wr_uart during the stall; bytes 4..7 resume unchanged; total 7 writes.
- Change x1 to 0xFF during SEND → frame still carries 0x51,0xA2; the next frame carries 0xF1,0xF2.
- Three frame_req pulses while busy → exactly two frames total; second header follows the first frame's frame_done.
- sel=5 with N_PLAYERS=2 → 0x50,0x01,0x02,0x03,0x04,0x05,0x5F.
- AUTO_PERIOD=100, auto_en=1, tx_full=0 → frames start every 100 cycles. Assert rst mid-frame → wr_uart=0 immediately, busy=0, no further bytes until the next request.
